// File: rtl/reg_write_demux_pkg.sv
// -----------------------------------------------------------------------------
// reg_write_demux_pkg
// Shared constants and types for the register-file write port.
//   DATA_W   : register / data port width
//   ADDR_W   : register index width
//   NUM_REGS : number of registers addressed by ADDR_W
//   reg_idx_t: register index type
//   word_t   : register data type
// -----------------------------------------------------------------------------
package reg_write_demux_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage : reg_write_demux_pkg

// File: rtl/reg_write_demux_demux_3to8.sv
// -----------------------------------------------------------------------------
// demux_3to8
// Combinational 1-of-8 decoder with enable, used to build the commit strobe.
// Ports:
//   en     : in  - decode enable; output is all-zero when low
//   sel    : in  - register index to decode
//   onehot : out - one-hot enable, bit sel set when en is high
// -----------------------------------------------------------------------------
module demux_3to8
    import reg_write_demux_pkg::*;
(
    input  logic                en,
    input  reg_idx_t            sel,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule : demux_3to8

// File: rtl/reg_write_demux.sv
// -----------------------------------------------------------------------------
// reg_write_demux
// Register-file write port: a write is staged on one edge and committed into
// one of NUM_REGS registers on the next, through a 1-of-N decoded strobe.
// Two combinational read ports feed decode, optionally bypassing the staged
// write so a pending value is visible one cycle early.
// Ports:
//   clk         : in  - system clock, rising edge
//   rst_n       : in  - asynchronous active-low reset
//   wr_en       : in  - write request this cycle
//   wr_addr     : in  - destination register index
//   wr_data     : in  - write data
//   rd_addr_a/b : in  - read port indices
//   rd_data_a/b : out - combinational read data
//   wr_onehot   : out - registered one-hot strobe of the committing write
//   stage_valid : out - a staged write is pending commit
// -----------------------------------------------------------------------------
module reg_write_demux
    import reg_write_demux_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int ADDR_W   = 3,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int NUM_REGS = 2 ** ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    output logic [NUM_REGS-1:0] wr_onehot,
    output logic                stage_valid
);

    logic [DATA_W-1:0]   regFile [NUM_REGS];
    logic [ADDR_W-1:0]   stageAddr_p1;
    logic [DATA_W-1:0]   stageData_p1;
    logic                vld_p1;
    logic                zeroHit_p1;
    logic [NUM_REGS-1:0] commitEn_p1;
    logic [NUM_REGS-1:0] wrOnehot_p2;

    // Read mux: the zero register always wins, then a matching staged write,
    // then the committed array contents.
    function automatic logic [DATA_W-1:0] readSel(
        input logic [ADDR_W-1:0] addr,
        input logic              stgVld,
        input logic [ADDR_W-1:0] stgAddr,
        input logic [DATA_W-1:0] stgData,
        input logic [DATA_W-1:0] arrVal
    );
        if ((ZERO_REG != 0) && (addr == '0)) begin
            return '0;
        end
        if ((BYPASS != 0) && stgVld && (addr == stgAddr)) begin
            return stgData;
        end
        return arrVal;
    endfunction

    // ---- p0 -> p1: stage the incoming write ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            stageAddr_p1 <= '0;
            stageData_p1 <= '0;
        end else begin
            vld_p1 <= wr_en;
            if (wr_en) begin
                stageAddr_p1 <= wr_addr;
                stageData_p1 <= wr_data;
            end
        end
    end

    // Writes aimed at the hardwired zero register decode to no strobe at all.
    assign zeroHit_p1 = (ZERO_REG != 0) && (stageAddr_p1 == '0);

    demux_3to8 uDemux (
        .en     (vld_p1 && !zeroHit_p1),
        .sel    (stageAddr_p1),
        .onehot (commitEn_p1)
    );

    // ---- p1 -> p2: commit into the array, register the strobe ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrOnehot_p2 <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            wrOnehot_p2 <= commitEn_p1;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commitEn_p1[i]) begin
                    regFile[i] <= stageData_p1;
                end
            end
        end
    end

    assign rd_data_a   = readSel(rd_addr_a, vld_p1, stageAddr_p1, stageData_p1, regFile[rd_addr_a]);
    assign rd_data_b   = readSel(rd_addr_b, vld_p1, stageAddr_p1, stageData_p1, regFile[rd_addr_b]);
    assign wr_onehot   = wrOnehot_p2;
    assign stage_valid = vld_p1;

endmodule : reg_write_demux

// File: tb/tb_reg_write_demux.sv
module tb_reg_write_demux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_a, rd_data_b;
    logic [7:0]  wr_onehot;
    logic        stage_valid;
    logic [15:0] nbRdA, nbRdB;
    logic [7:0]  nbOnehot;
    logic        nbStageValid;

    int nPass  = 0;
    int nTotal = 0;

    // reference model state
    logic [15:0] mArr [8];
    logic        mVld;
    logic [2:0]  mAddr;
    logic [15:0] mData;
    logic [7:0]  expQ [$];
    logic [7:0]  expOh;

    always #5 clk = ~clk;

    reg_write_demux #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
        .rd_data_b(rd_data_b), .wr_onehot(wr_onehot), .stage_valid(stage_valid)
    );

    reg_write_demux #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) dutNb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(nbRdA),
        .rd_data_b(nbRdB), .wr_onehot(nbOnehot), .stage_valid(nbStageValid)
    );

    function automatic logic [15:0] mRead(input logic [2:0] a, input bit byp);
        if (a == 3'd0) return 16'h0000;
        if (byp && mVld && (a == mAddr)) return mData;
        return mArr[a];
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 8; i++) mArr[i] = 16'h0000;
        mVld  = 1'b0;
        mAddr = 3'd0;
        mData = 16'h0000;
        expQ.delete();
    endtask

    // One clock edge: push the expected strobe for this cycle's write, then
    // advance the model the way the array should advance.
    task automatic tick();
        expQ.push_back((wr_en && wr_addr != 3'd0) ? (8'd1 << wr_addr) : 8'd0);
        @(posedge clk);
        if (mVld && mAddr != 3'd0) mArr[mAddr] = mData;
        mVld = wr_en;
        if (wr_en) begin
            mAddr = wr_addr;
            mData = wr_data;
        end
        #1;
    endtask

    task automatic test_reset_initial();
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        modelClear();
        #12;
        for (int i = 0; i < 8; i += 3) begin
            rd_addr_a = 3'(i);
            #1;
            nTotal++;
            if (rd_data_a !== 16'h0000) $display("FAIL init_rd a=%0d: got %h expected 0000", i, rd_data_a);
            else nPass++;
        end
        nTotal++;
        if (stage_valid !== 1'b0 || wr_onehot !== 8'h00)
            $display("FAIL init_ctrl: got sv=%b oh=%h expected sv=0 oh=00", stage_valid, wr_onehot);
        else nPass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF; rd_addr_a = 3'd3;
        tick();
        wr_en = 1'b0;
        nTotal++;
        if (stage_valid !== 1'b1) $display("FAIL sw_stage: got %b expected 1", stage_valid);
        else nPass++;
        nTotal++;
        if (rd_data_a !== 16'hBEEF) $display("FAIL sw_bypass: got %h expected beef", rd_data_a);
        else nPass++;
        nTotal++;
        if (nbRdA !== 16'h0000) $display("FAIL sw_nobypass: got %h expected 0000", nbRdA);
        else nPass++;
        tick();
        expOh = expQ.pop_front();
        nTotal++;
        if (wr_onehot !== expOh || wr_onehot !== 8'b0000_1000)
            $display("FAIL sw_onehot: got %h expected %h", wr_onehot, expOh);
        else nPass++;
        nTotal++;
        if (rd_data_a !== 16'hBEEF || nbRdA !== 16'hBEEF)
            $display("FAIL sw_array: got %h/%h expected beef/beef", rd_data_a, nbRdA);
        else nPass++;
        nTotal++;
        if (stage_valid !== 1'b0) $display("FAIL sw_stage_clr: got %b expected 0", stage_valid);
        else nPass++;
        tick();
        expOh = expQ.pop_front();
        nTotal++;
        if (wr_onehot !== expOh) $display("FAIL sw_onehot_idle: got %h expected %h", wr_onehot, expOh);
        else nPass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  addrs [3] = '{3'd1, 3'd2, 3'd1};
        logic [15:0] datas [3] = '{16'h1111, 16'h2222, 16'h3333};
        logic [7:0]  seqExp [3] = '{8'h02, 8'h04, 8'h02};
        for (int k = 0; k < 5; k++) begin
            wr_en = (k < 3);
            if (k < 3) begin
                wr_addr = addrs[k];
                wr_data = datas[k];
            end
            tick();
            expOh = expQ.pop_front();
            nTotal++;
            if (wr_onehot !== expOh) $display("FAIL b2b_onehot[%0d]: got %h expected %h", k, wr_onehot, expOh);
            else nPass++;
            if (k >= 1 && k <= 3) begin
                nTotal++;
                if (wr_onehot !== seqExp[k-1])
                    $display("FAIL b2b_seq[%0d]: got %h expected %h", k - 1, wr_onehot, seqExp[k-1]);
                else nPass++;
            end
        end
        rd_addr_a = 3'd1; rd_addr_b = 3'd2;
        #1;
        nTotal++;
        if (rd_data_a !== 16'h3333 || rd_data_b !== 16'h2222)
            $display("FAIL b2b_final: got %h/%h expected 3333/2222", rd_data_a, rd_data_b);
        else nPass++;
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; rd_addr_b = 3'd0;
        tick();
        wr_en = 1'b0;
        expOh = expQ.pop_front();
        nTotal++;
        if (stage_valid !== 1'b1 || rd_data_b !== 16'h0000)
            $display("FAIL zr_stage: got sv=%b rd=%h expected sv=1 rd=0000", stage_valid, rd_data_b);
        else nPass++;
        for (int k = 0; k < 2; k++) begin
            tick();
            expOh = expQ.pop_front();
            nTotal++;
            if (wr_onehot !== 8'h00 || wr_onehot !== expOh || rd_data_b !== 16'h0000)
                $display("FAIL zr_commit[%0d]: got oh=%h rd=%h expected oh=00 rd=0000", k, wr_onehot, rd_data_b);
            else nPass++;
        end
    endtask

    task automatic test_dual_read_bypass();
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0044;
        tick();
        expOh = expQ.pop_front();
        wr_en = 1'b0;
        tick();
        expOh = expQ.pop_front();
        wr_en = 1'b1; wr_data = 16'h0055; rd_addr_a = 3'd4; rd_addr_b = 3'd4;
        tick();
        expOh = expQ.pop_front();
        wr_en = 1'b0;
        nTotal++;
        if (rd_data_a !== 16'h0055 || rd_data_b !== 16'h0055)
            $display("FAIL dual_bypass: got %h/%h expected 0055/0055", rd_data_a, rd_data_b);
        else nPass++;
        nTotal++;
        if (nbRdA !== 16'h0044) $display("FAIL dual_stale: got %h expected 0044", nbRdA);
        else nPass++;
        rd_addr_b = 3'd6;
        #1;
        nTotal++;
        if (rd_data_b !== 16'h0000) $display("FAIL dual_other: got %h expected 0000", rd_data_b);
        else nPass++;
        tick();
        expOh = expQ.pop_front();
        nTotal++;
        if (wr_onehot !== expOh) $display("FAIL dual_onehot: got %h expected %h", wr_onehot, expOh);
        else nPass++;
    endtask

    task automatic test_same_cycle();
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h7777; rd_addr_a = 3'd7;
        #1;
        nTotal++;
        if (rd_data_a !== 16'h0000) $display("FAIL same_cycle: got %h expected 0000", rd_data_a);
        else nPass++;
        tick();
        expOh = expQ.pop_front();
        wr_en = 1'b0;
        nTotal++;
        if (rd_data_a !== 16'h7777) $display("FAIL same_next: got %h expected 7777", rd_data_a);
        else nPass++;
        tick();
        expOh = expQ.pop_front();
        nTotal++;
        if (wr_onehot !== expOh) $display("FAIL same_onehot: got %h expected %h", wr_onehot, expOh);
        else nPass++;
    endtask

    task automatic test_reset_midrun();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h5555; rd_addr_a = 3'd5;
        tick();
        wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        nTotal++;
        if (rd_data_a !== 16'h0000 || stage_valid !== 1'b0 || wr_onehot !== 8'h00)
            $display("FAIL rst_mid: got rd=%h sv=%b oh=%h expected 0000/0/00", rd_data_a, stage_valid, wr_onehot);
        else nPass++;
        for (int i = 1; i < 8; i += 2) begin
            rd_addr_b = 3'(i);
            #1;
            nTotal++;
            if (rd_data_b !== 16'h0000) $display("FAIL rst_rd b=%0d: got %h expected 0000", i, rd_data_b);
            else nPass++;
        end
        modelClear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        tick();
        expOh = expQ.pop_front();
        nTotal++;
        if (rd_data_a !== 16'h0000 || wr_onehot !== expOh)
            $display("FAIL rst_after: got rd=%h oh=%h expected 0000/%h", rd_data_a, wr_onehot, expOh);
        else nPass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            wr_en     = ($urandom_range(0, 3) != 0);
            wr_addr   = 3'($urandom_range(0, 7));
            wr_data   = 16'($urandom);
            rd_addr_a = 3'($urandom_range(0, 7));
            rd_addr_b = (k % 4 == 0) ? wr_addr : 3'($urandom_range(0, 7));
            tick();
            if (expQ.size() > 1) begin
                expOh = expQ.pop_front();
                nTotal++;
                if (wr_onehot !== expOh) $display("FAIL rnd_onehot[%0d]: got %h expected %h", k, wr_onehot, expOh);
                else nPass++;
            end
            nTotal++;
            if (rd_data_a !== mRead(rd_addr_a, 1'b1) || rd_data_b !== mRead(rd_addr_b, 1'b1))
                $display("FAIL rnd_rd[%0d]: got %h/%h expected %h/%h", k, rd_data_a, rd_data_b,
                         mRead(rd_addr_a, 1'b1), mRead(rd_addr_b, 1'b1));
            else nPass++;
            nTotal++;
            if (nbRdA !== mRead(rd_addr_a, 1'b0) || stage_valid !== mVld)
                $display("FAIL rnd_nb[%0d]: got %h sv=%b expected %h sv=%b", k, nbRdA, stage_valid,
                         mRead(rd_addr_a, 1'b0), mVld);
            else nPass++;
        end
        wr_en = 1'b0;
    endtask

    initial begin
        test_reset_initial();
        test_single_write();
        test_back_to_back();
        test_zero_reg();
        test_dual_read_bypass();
        test_same_cycle();
        test_reset_midrun();
        test_random();
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule : tb_reg_write_demux

// File: doc/reg_write_demux.md
Name: reg_write_demux

Overview:
- Register-file write port for the pipelined processor: routes a 3-bit destination address and a data word to one of 8 registers.
- It is the distribution end of the 3-bit 2:1 destination-select path: the decode stage selects which 3-bit register index is the destination; this block decodes that index 1-of-8 and commits the write.
- Writes are staged one cycle before commit.
- Two combinational read ports, with optional bypass from the staging register, feed the decode stage.

Parameters:
- DATA_W, 16, width of each register and of the data ports.
- ADDR_W, 3, register index width; NUM_REGS = 2**ADDR_W = 8.
- ZERO_REG, 1, when 1 register 0 is hardwired to 0 and writes to it are discarded.
- BYPASS, 1, when 1 reads of an address with a pending staged write return the staged data.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request this cycle.
- wr_addr  input  ADDR_W  destination register index.
- wr_data  input  DATA_W  write data.
- rd_addr_a  input  ADDR_W  read port A index.
- rd_addr_b  input  ADDR_W  read port B index.
- rd_data_a  output  DATA_W  read port A data (combinational).
- rd_data_b  output  DATA_W  read port B data (combinational).
- wr_onehot  output  NUM_REGS  registered one-hot write strobe for the committing write; all-zero when nothing commits.
- stage_valid  output  1  a staged write is pending commit.

Behaviour:
- Reset: single clock (clk); reset rst_n is asynchronous, active-low.
  - While rst_n=0: all 8 registers = 0, stage_valid = 0, staged addr/data = 0, wr_onehot = 0.
  - rd_data_* reflects the cleared array.
- Stage (edge N): if wr_en=1, capture wr_addr/wr_data into the staging register and set stage_valid=1; otherwise stage_valid=0.
- Commit (edge N+1):
  - If stage_valid=1, demux the staged address into a 1-of-8 enable.
  - The selected register loads the staged data.
  - wr_onehot shows that enable from edge N+1 to edge N+2.
  - Write-to-visible-in-array latency = 2 edges.
- ZERO_REG=1 and staged addr=0: the decoded enable is all-zero, register 0 is unchanged, wr_onehot = 0. stage_valid still pulses.
- Back-to-back writes: one write per cycle sustained with no stall. Commit of write k and staging of write k+1 happen on the same edge.
- Same address written on consecutive cycles: the later write wins; the array ends with the last value.
- Reads are combinational, ports independent, same address on both ports allowed.
  - BYPASS=1 and stage_valid=1 and rd_addr == staged addr (and not the zero reg when ZERO_REG=1): return staged data.
  - Otherwise return array contents.
  - Reading address 0 with ZERO_REG=1 always returns 0.
  - BYPASS=0: reads see only the array, so there is a 1-cycle stale window.
- No bypass from the wr_data input itself (same-cycle write/read returns the old value).
- Reset mid-operation: a pending staged write is dropped and never commits. Registers return to 0 asynchronously.
- Out-of-range addresses are impossible (ADDR_W covers NUM_REGS exactly).

Decomposition:
- Shared package: DATA_W and ADDR_W constants, NUM_REGS derived constant, reg_idx_t (ADDR_W bits) and word_t (DATA_W bits) typedefs.
- One sub-module: demux_3to8. Combinational 1-of-8 decode with an enable input; output all-zero when enable=0. Instantiated once for the commit strobe.

Test Plan:
- Reset: drive rst_n=0 mid-run with a staged write pending.
  - Required: all reads return 0x0000, stage_valid=0, wr_onehot=0.
  - After release, register 5 still reads 0.
- Single write: wr_en=1, addr=3, data=0xBEEF at edge 0.
  - stage_valid=1 after edge 0.
  - wr_onehot=8'b0000_1000 after edge 1.
  - rd_addr_a=3 returns 0xBEEF after edge 0 (bypass) and after edge 1 (array).
  - With BYPASS=0, rd_addr_a=3 returns 0 after edge 0.
- Back-to-back: writes addr 1=0x1111, addr 2=0x2222, addr 1=0x3333 on three consecutive edges.
  - wr_onehot sequence: 0x02, 0x04, 0x02.
  - Final reads: r1=0x3333, r2=0x2222.
- Zero register: write addr 0 = 0xFFFF with ZERO_REG=1.
  - wr_onehot stays 0x00; rd_addr_b=0 returns 0x0000 throughout.
- Dual read plus bypass: r4=0x0044 committed, then stage addr 4=0x0055.
  - rd_addr_a=4 and rd_addr_b=4 both return 0x0055 while staged.
  - rd_addr_b=6 returns array value 0x0000.
- Same-cycle write/read: wr_en=1, wr_addr=7=0x7777 with rd_addr_a=7 in the same cycle before the edge.
  - Read returns the old value 0x0000.
